// File: rtl/gloves_pos_ctl.sv
// gloves_pos_ctl: frame-synchronous, clamped, step-limited gloves position.
// clk/rst: clock, async active-high reset
// mouse_xpos/mouse_ypos: raw mouse coordinates, sampled at frame start
// vblnk: vertical blanking, its rising edge marks a frame start
// enable: 1 follows the mouse, 0 recentres to X_INIT/Y_INIT
// xpos/ypos: registered gloves position, pos_valid: one-cycle update pulse
module gloves_pos_ctl #(
  parameter int H_MAX = 1024,
  parameter int V_MAX = 768,
  parameter int STEP_MAX = 16,
  parameter int X_INIT = 512,
  parameter int Y_INIT = 384
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] mouse_xpos,
  input  logic [11:0] mouse_ypos,
  input  logic        vblnk,
  input  logic        enable,
  output logic [11:0] xpos,
  output logic [11:0] ypos,
  output logic        pos_valid
);
  localparam logic [1:0] IDLE = 2'd0, LIMIT = 2'd1, COMMIT = 2'd2;
  localparam logic [11:0] HM = 12'(H_MAX), VM = 12'(V_MAX), XI = 12'(X_INIT), YI = 12'(Y_INIT);
  localparam logic [11:0] ST = 12'(STEP_MAX);
  localparam logic signed [12:0] STS = 13'(STEP_MAX);
  logic [1:0] state;
  logic vblnk_q, recentre;
  logic [11:0] cap_x, cap_y, nxt_x, nxt_y;
  logic fs;
  assign fs = vblnk & ~vblnk_q;
  // the 13-bit signed delta cannot wrap, and cap >= 0 keeps o - ST non-negative
  function automatic logic [11:0] lim(input logic [11:0] c, input logic [11:0] o, input logic rc);
    logic signed [12:0] d;
    d = $signed({1'b0, c}) - $signed({1'b0, o});
    return rc ? c : d > STS ? o + ST : d < -STS ? o - ST : c;
  endfunction
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      vblnk_q <= 1'b1;
      recentre <= 1'b0;
      cap_x <= '0;
      cap_y <= '0;
      nxt_x <= '0;
      nxt_y <= '0;
      xpos <= XI;
      ypos <= YI;
      pos_valid <= 1'b0;
    end else begin
      vblnk_q <= vblnk;
      pos_valid <= 1'b0;
      if (state == IDLE && fs) begin
        cap_x <= enable ? (mouse_xpos > HM ? HM : mouse_xpos) : XI;
        cap_y <= enable ? (mouse_ypos > VM ? VM : mouse_ypos) : YI;
        recentre <= ~enable;
        state <= LIMIT;
      end else if (state == LIMIT) begin
        nxt_x <= lim(cap_x, xpos, recentre);
        nxt_y <= lim(cap_y, ypos, recentre);
        state <= COMMIT;
      end else if (state == COMMIT) begin
        xpos <= nxt_x;
        ypos <= nxt_y;
        pos_valid <= 1'b1;
        state <= IDLE;
      end
    end
endmodule

// File: tb/tb_gloves_pos_ctl.sv
// tb_gloves_pos_ctl: scoreboard bench for gloves_pos_ctl with directed frames.
module tb_gloves_pos_ctl;
  logic clk = 1'b0, rst = 1'b1, vblnk = 1'b1, enable = 1'b0;
  logic [11:0] mouse_xpos = '0, mouse_ypos = '0;
  logic [11:0] xpos, ypos;
  logic pos_valid;
  int total = 0, bad = 0, cyc = 0;
  typedef struct {int x; int y; int c;} exp_t;
  exp_t q[$];
  exp_t e;
  gloves_pos_ctl dut (
    .clk(clk), .rst(rst), .mouse_xpos(mouse_xpos), .mouse_ypos(mouse_ypos),
    .vblnk(vblnk), .enable(enable), .xpos(xpos), .ypos(ypos), .pos_valid(pos_valid)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string n, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", n, act, req);
    end
  endtask
  always @(negedge clk)
    if (pos_valid) begin
      if (q.size() == 0) chk("unexpected pos_valid", 1, 0);
      else begin
        e = q.pop_front();
        chk("update xpos", int'(xpos), e.x);
        chk("update ypos", int'(ypos), e.y);
        chk("update cycle", cyc, e.c);
      end
    end
  task automatic frame(input int mx, input int my, input int en, input int ex, input int ey);
    @(negedge clk) vblnk = 1'b0;
    @(negedge clk);
    mouse_xpos = 12'(mx);
    mouse_ypos = 12'(my);
    enable = en[0];
    vblnk = 1'b1;
    q.push_back('{ex, ey, cyc + 3});
    @(negedge clk);
    mouse_xpos = 12'hfff;
    mouse_ypos = 12'hfff;
    enable = ~en[0];
    repeat (5) @(negedge clk);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk("reset xpos", int'(xpos), 512);
    chk("reset ypos", int'(ypos), 384);
    chk("reset pos_valid", int'(pos_valid), 0);
    rst = 1'b0;
    repeat (10) @(negedge clk) begin
      chk("idle xpos", int'(xpos), 512);
      chk("idle ypos", int'(ypos), 384);
    end
    frame(520, 380, 1, 520, 380);
    frame(700, 100, 0, 512, 384);
    frame(700, 100, 1, 528, 368);
    frame(700, 100, 1, 544, 352);
    frame(700, 100, 1, 560, 336);
    for (int i = 1; i <= 30; i++)
      frame(1500, 900, 1, 560 + 16 * i > 1024 ? 1024 : 560 + 16 * i, 336 + 16 * i > 768 ? 768 : 336 + 16 * i);
    frame(1500, 900, 0, 512, 384);
    @(negedge clk) vblnk = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      mouse_xpos = 12'($urandom_range(0, 4095));
      mouse_ypos = 12'($urandom_range(0, 4095));
      enable = i[0];
      chk("hold xpos", int'(xpos), 512);
      chk("hold ypos", int'(ypos), 384);
    end
    frame(530, 400, 1, 528, 400);
    @(negedge clk) vblnk = 1'b0;
    mouse_xpos = 12'd600;
    mouse_ypos = 12'd500;
    enable = 1'b1;
    @(negedge clk) vblnk = 1'b1;
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("async reset xpos", int'(xpos), 512);
    chk("async reset ypos", int'(ypos), 384);
    chk("async reset pos_valid", int'(pos_valid), 0);
    @(negedge clk) rst = 1'b0;
    repeat (8) @(negedge clk);
    chk("post reset xpos", int'(xpos), 512);
    frame(600, 500, 1, 528, 400);
    repeat (5) @(negedge clk);
    chk("scoreboard drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
